// File: rtl/lms_sample_scheduler.sv
// Paces codec sample pairs into the shared LMS adaptive filter: buffers pairs,
// strobes one pair per filter budget, and captures the filter's estimate/error.
module lms_sample_scheduler #(
  parameter int STAGE         = 256,
  parameter int SAMPLE_CYCLES = STAGE + 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [15:0] ref_in,
  input  logic signed [15:0] mic_in,
  input  logic               in_valid,
  output logic signed [15:0] flt_x,
  output logic signed [15:0] flt_d,
  output logic               flt_en,
  input  logic signed [15:0] flt_y,
  input  logic signed [15:0] flt_e,
  output logic signed [15:0] out_est,
  output logic signed [15:0] out_err,
  output logic               out_valid,
  output logic               busy,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic [7:0]         drop_cnt
);

  // The guard can never be shorter than the filter's pipeline depth.
  localparam int GUARD = (SAMPLE_CYCLES >= STAGE + 12) ? SAMPLE_CYCLES : STAGE + 12;
  localparam int CW    = $clog2(GUARD + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NW    = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   guard_cnt;
  logic            guard_done;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;
  logic            full, empty, pop, wr_en, drop;

  assign full       = (count == NW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign wr_en      = in_valid && (!full || pop);
  assign drop       = in_valid && full && !pop;
  assign guard_done = (guard_cnt == CW'(GUARD - 1));

  assign flt_en     = (state == ISSUE);
  assign out_valid  = (state == CAPTURE);
  assign busy       = (state == ISSUE) || (state == WAIT);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          next_state = ISSUE;
          pop        = 1'b1;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (guard_done) next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ref_in, mic_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      guard_cnt <= '0;
      flt_x     <= '0;
      flt_d     <= '0;
      out_est   <= '0;
      out_err   <= '0;
    end else begin
      state <= next_state;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        flt_x  <= mem[rd_ptr][31:16];
        flt_d  <= mem[rd_ptr][15:0];
      end
      case ({wr_en, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      if (state == ISSUE)
        guard_cnt <= '0;
      else if (state == WAIT && !guard_done)
        guard_cnt <= guard_cnt + CW'(1);
      // Sample on the last WAIT edge so the result is stable alongside out_valid.
      if (state == WAIT && guard_done) begin
        out_est <= flt_y;
        out_err <= flt_e;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_lms_sample_scheduler.sv
// Directed bench for lms_sample_scheduler with a simple filter model that
// answers each flt_en with ~x / d^00FF after a pipeline delay.
module tb_lms_sample_scheduler;

  localparam int STAGE   = 256;
  localparam int SC      = STAGE + 16;
  localparam int SPACING = SC + 3;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, in_valid = 1'b0, ovf_clr = 1'b0;
  logic [15:0] ref_in = '0, mic_in = '0, flt_y = '0, flt_e = '0;
  logic [15:0] flt_x, flt_d, out_est, out_err;
  logic        flt_en, out_valid, busy, ovf;
  logic [7:0]  drop_cnt;

  int n_vec = 0, n_err = 0, cyc = 0;
  int          en_cyc[$], ov_cyc[$];
  logic [15:0] en_x[$], en_d[$], ov_est[$], ov_err[$];
  logic [15:0] mx = '0, md = '0;
  int          mcnt = 0;

  lms_sample_scheduler #(.STAGE(STAGE), .SAMPLE_CYCLES(SC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ref_in(ref_in), .mic_in(mic_in),
    .in_valid(in_valid), .flt_x(flt_x), .flt_d(flt_d), .flt_en(flt_en),
    .flt_y(flt_y), .flt_e(flt_e), .out_est(out_est), .out_err(out_err),
    .out_valid(out_valid), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Filter model plus event logger, both sampled on the falling edge.
  always @(negedge clk) begin
    if (flt_en === 1'b1) begin
      en_cyc.push_back(cyc); en_x.push_back(flt_x); en_d.push_back(flt_d);
      mx = flt_x; md = flt_d; mcnt = 0;
      flt_y = 16'hDEAD; flt_e = 16'hDEAD;
    end else begin
      mcnt++;
      if (mcnt == STAGE + 8) begin
        flt_y = ~mx;
        flt_e = md ^ 16'h00FF;
      end
    end
    if (out_valid === 1'b1) begin
      ov_cyc.push_back(cyc); ov_est.push_back(out_est); ov_err.push_back(out_err);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    en_cyc.delete(); en_x.delete(); en_d.delete();
    ov_cyc.delete(); ov_est.delete(); ov_err.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; ovf_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_logs();
  endtask

  task automatic pulse(input logic [15:0] x, input logic [15:0] d);
    ref_in = x; mic_in = d; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget);
    for (int i = 0; i < budget && ov_cyc.size() < n; i++) step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_vec++;
    if ({flt_x, flt_d, out_est, out_err} !== 64'h0) begin
      n_err++; $display("[TB] FAIL reset_data: got %h required 0", {flt_x, flt_d, out_est, out_err});
    end
    n_vec++;
    if ({flt_en, out_valid, busy, ovf} !== 4'b0) begin
      n_err++; $display("[TB] FAIL reset_flags: got %b required 0000", {flt_en, out_valid, busy, ovf});
    end
    n_vec++;
    if (drop_cnt !== 8'd0) begin
      n_err++; $display("[TB] FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
    end
  endtask

  task automatic test_single_pair();
    int in_c;
    do_reset();
    enable = 1'b1;
    in_c = cyc;
    pulse(16'h1234, 16'hF000);
    wait_outs(1, SC + 20);
    step(3);
    n_vec++;
    if (ov_cyc.size() != 1 || en_cyc.size() != 1) begin
      n_err++; $display("[TB] FAIL single_counts: got en=%0d out=%0d required 1/1", en_cyc.size(), ov_cyc.size());
    end else begin
      n_vec++;
      if (en_cyc[0] - in_c != 2) begin
        n_err++; $display("[TB] FAIL single_issue_lat: got %0d required 2", en_cyc[0] - in_c);
      end
      n_vec++;
      if ({en_x[0], en_d[0]} !== 32'h1234_F000) begin
        n_err++; $display("[TB] FAIL single_flt_xd: got %h required 1234f000", {en_x[0], en_d[0]});
      end
      n_vec++;
      if (ov_cyc[0] - en_cyc[0] != SC + 1) begin
        n_err++; $display("[TB] FAIL single_out_lat: got %0d required %0d", ov_cyc[0] - en_cyc[0], SC + 1);
      end
      n_vec++;
      if ({ov_est[0], ov_err[0]} !== 32'hEDCB_F0FF) begin
        n_err++; $display("[TB] FAIL single_result: got %h required edcbf0ff", {ov_est[0], ov_err[0]});
      end
    end
    n_vec++;
    if ({busy, flt_x} !== {1'b0, 16'h1234}) begin
      n_err++; $display("[TB] FAIL single_hold: got %h required 01234", {busy, flt_x});
    end
  endtask

  task automatic test_burst();
    logic [15:0] x;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) pulse(16'h1000 + 16'(i) * 16'h0111, 16'h8000 + 16'(i));
    wait_outs(4, 4 * SPACING + 20);
    n_vec++;
    if ({ovf, drop_cnt} !== 9'h0) begin
      n_err++; $display("[TB] FAIL burst_nodrop: got ovf=%b drop=%0d required 0/0", ovf, drop_cnt);
    end
    n_vec++;
    if (en_cyc.size() != 4 || ov_cyc.size() != 4) begin
      n_err++; $display("[TB] FAIL burst_counts: got en=%0d out=%0d required 4/4", en_cyc.size(), ov_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        x = 16'h1000 + 16'(i) * 16'h0111;
        n_vec++;
        if ({en_x[i], en_d[i], ov_est[i]} !== {x, 16'h8000 + 16'(i), ~x}) begin
          n_err++; $display("[TB] FAIL burst_order[%0d]: got %h required %h", i,
                            {en_x[i], en_d[i], ov_est[i]}, {x, 16'h8000 + 16'(i), ~x});
        end
        if (i > 0) begin
          n_vec++;
          if (en_cyc[i] - en_cyc[i-1] != SPACING) begin
            n_err++; $display("[TB] FAIL burst_spacing[%0d]: got %0d required %0d", i, en_cyc[i] - en_cyc[i-1], SPACING);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) pulse(16'hA000 + 16'(i), 16'h5000 + 16'(i));
    n_vec++;
    if ({busy, ovf, drop_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      n_err++; $display("[TB] FAIL ovf_set: got busy=%b ovf=%b drop=%0d required 1/1/1", busy, ovf, drop_cnt);
    end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    n_vec++;
    if ({ovf, drop_cnt} !== 9'h0) begin
      n_err++; $display("[TB] FAIL ovf_clear: got ovf=%b drop=%0d required 0/0", ovf, drop_cnt);
    end
    wait_outs(5, 5 * SPACING + 20);
    step(SPACING);
    n_vec++;
    if (en_cyc.size() != 5) begin
      n_err++; $display("[TB] FAIL ovf_issued: got %0d required 5", en_cyc.size());
    end else begin
      n_vec++;
      if (en_x[4] !== 16'hA004) begin
        n_err++; $display("[TB] FAIL ovf_last_kept: got %h required a004", en_x[4]);
      end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) pulse(16'hB000 + 16'(i), 16'h0100 + 16'(i));
    step(10);
    enable = 1'b0;
    wait_outs(1, SPACING);
    n_vec++;
    if (ov_cyc.size() != 1 || ov_est[0] !== 16'h4FFF) begin
      n_err++; $display("[TB] FAIL endrop_capture: got n=%0d est=%h required 1/4fff", ov_cyc.size(), out_est);
    end
    step(2 * SPACING);
    n_vec++;
    if (en_cyc.size() != 1 || busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL endrop_hold: got en=%0d busy=%b required 1/0", en_cyc.size(), busy);
    end
    enable = 1'b1;
    wait_outs(3, 2 * SPACING + 20);
    n_vec++;
    if (en_cyc.size() != 3) begin
      n_err++; $display("[TB] FAIL endrop_resume: got %0d required 3", en_cyc.size());
    end else begin
      n_vec++;
      if ({en_x[1], en_x[2]} !== 32'hB001_B002) begin
        n_err++; $display("[TB] FAIL endrop_order: got %h required b001b002", {en_x[1], en_x[2]});
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    pulse(16'hC0DE, 16'h0BAD);
    for (int i = 0; i < 10 && en_cyc.size() == 0; i++) step(1);
    step(10);
    n_vec++;
    if ({busy, flt_x} !== {1'b1, 16'hC0DE}) begin
      n_err++; $display("[TB] FAIL arst_pre: got %h required 1c0de", {busy, flt_x});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({flt_x, flt_d, out_est, out_err, flt_en, out_valid, busy, ovf, drop_cnt} !== 76'h0) begin
      n_err++; $display("[TB] FAIL arst_outputs: got %h required 0",
                        {flt_x, flt_d, out_est, out_err, flt_en, out_valid, busy, ovf, drop_cnt});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    step(SC + 10);
    n_vec++;
    if (ov_cyc.size() != 0 || en_cyc.size() != 0) begin
      n_err++; $display("[TB] FAIL arst_after: got en=%0d out=%0d required 0/0", en_cyc.size(), ov_cyc.size());
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) pulse(16'h0F00 + 16'(i), 16'h00F0);
    n_vec++;
    if ({ovf, drop_cnt} !== 9'h0) begin
      n_err++; $display("[TB] FAIL sat_fill: got ovf=%b drop=%0d required 0/0", ovf, drop_cnt);
    end
    for (int i = 0; i < 10; i++) pulse(16'h7777, 16'h8888);
    n_vec++;
    if ({ovf, drop_cnt} !== {1'b1, 8'd10}) begin
      n_err++; $display("[TB] FAIL sat_ten: got ovf=%b drop=%0d required 1/10", ovf, drop_cnt);
    end
    ovf_clr = 1'b1;
    pulse(16'h7777, 16'h8888);
    ovf_clr = 1'b0;
    n_vec++;
    if ({ovf, drop_cnt} !== 9'h0) begin
      n_err++; $display("[TB] FAIL sat_clr_wins: got ovf=%b drop=%0d required 0/0", ovf, drop_cnt);
    end
    pulse(16'h7777, 16'h8888);
    n_vec++;
    if ({ovf, drop_cnt} !== {1'b1, 8'd1}) begin
      n_err++; $display("[TB] FAIL sat_one: got ovf=%b drop=%0d required 1/1", ovf, drop_cnt);
    end
    in_valid = 1'b1;
    step(300);
    in_valid = 1'b0;
    step(1);
    n_vec++;
    if ({ovf, drop_cnt} !== {1'b1, 8'd255}) begin
      n_err++; $display("[TB] FAIL sat_limit: got ovf=%b drop=%0d required 1/255", ovf, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_burst();
    test_overflow();
    test_enable_drop();
    test_async_reset();
    test_drop_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
